// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Shares one external SRAM controller between two bus masters: m0 (SoC bus)
//   and m1 (DMA / video fetch). Each master uses a req/ack handshake and only
//   one SRAM access is in flight at a time. A watchdog aborts an access whose
//   controller ready never arrives, returning err=1 and all-ones read data.
//
//   Build option: define SRAM_ARB_RR_EN for round-robin tie breaking.
//   Without it, m0 always wins a tie (m1 may starve under continuous m0 load).
//
// Parameters
//   AW       address width (masters and SRAM)
//   DW       data width (masters and SRAM)
//   TIMEOUT  max cycles in BUSY before abort; 0 disables the watchdog
//
// Ports
//   clk, reset_n                      clock, synchronous active-low reset
//   m0_req/we/addr/wdata              master 0 request (held until ack)
//   m0_ack/err/rdata                  master 0 completion pulse, abort flag, read data
//   m1_req/we/addr/wdata              master 1 request (held until ack)
//   m1_ack/err/rdata                  master 1 completion pulse, abort flag, read data
//   sram_read, sram_write             access strobes, high for the whole access
//   sram_address, sram_data_write     latched address / write data
//   sram_data_read, sram_ready        controller read data and completion
//   busy                              high while BUSY or RECOVER
//   owner                             master owning the current / last access
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int AW      = 18,
   parameter int DW      = 16,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_rdata,
   output logic          sram_read,
   output logic          sram_write,
   output logic [AW-1:0] sram_address,
   output logic [DW-1:0] sram_data_write,
   input  logic [DW-1:0] sram_data_read,
   input  logic          sram_ready,
   output logic          busy,
   output logic          owner
);

   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [WDW-1:0]  wdog_r, wdog_s;
   logic            last_grant_r, last_grant_s;
   logic            owner_r, owner_s;
   logic            busy_r, busy_s;
   logic            sram_read_r, sram_read_s;
   logic            sram_write_r, sram_write_s;
   logic [AW-1:0]   sram_address_r, sram_address_s;
   logic [DW-1:0]   sram_data_write_r, sram_data_write_s;
   logic            m0_ack_r, m0_ack_s, m1_ack_r, m1_ack_s;
   logic            m0_err_r, m0_err_s, m1_err_r, m1_err_s;
   logic [DW-1:0]   m0_rdata_r, m0_rdata_s, m1_rdata_r, m1_rdata_s;
   logic            winner_s;
   logic            sel_we_s;
   logic            wdog_hit_s;

   // Arbitration: pick which master gets the next access when any req is up.
   always_comb begin
      winner_s = 1'b0;
`ifdef SRAM_ARB_RR_EN
      if (m0_req && m1_req) begin
         winner_s = ~last_grant_r;
      end else begin
         winner_s = ~m0_req;
      end
`else
      winner_s = ~m0_req;
`endif
   end

   // Watchdog expiry; ready in the same cycle takes precedence in the FSM.
   always_comb begin
      wdog_hit_s = 1'b0;
      if (TIMEOUT != 0) begin
         wdog_hit_s = (wdog_r == WD_LAST);
      end else begin
         wdog_hit_s = 1'b0;
      end
   end

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_s           = state_r;
      wdog_s            = wdog_r;
      last_grant_s      = last_grant_r;
      owner_s           = owner_r;
      busy_s            = busy_r;
      sram_read_s       = sram_read_r;
      sram_write_s      = sram_write_r;
      sram_address_s    = sram_address_r;
      sram_data_write_s = sram_data_write_r;
      m0_ack_s          = m0_ack_r;
      m1_ack_s          = m1_ack_r;
      m0_err_s          = m0_err_r;
      m1_err_s          = m1_err_r;
      m0_rdata_s        = m0_rdata_r;
      m1_rdata_s        = m1_rdata_r;
      sel_we_s          = winner_s ? m1_we : m0_we;

      case (state_r)
         ST_IDLE: begin
            if (m0_req || m1_req) begin
               sram_address_s    = winner_s ? m1_addr : m0_addr;
               sram_data_write_s = winner_s ? m1_wdata : m0_wdata;
               sram_write_s      = sel_we_s;
               sram_read_s       = ~sel_we_s;
               owner_s           = winner_s;
               last_grant_s      = winner_s;
               wdog_s            = {WDW{1'b0}};
               busy_s            = 1'b1;
               state_s           = ST_BUSY;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_BUSY: begin
            wdog_s = wdog_r + 1'b1;
            if (sram_ready) begin
               sram_read_s  = 1'b0;
               sram_write_s = 1'b0;
               state_s      = ST_RECOVER;
               if (owner_r) begin
                  m1_ack_s = 1'b1;
                  m1_err_s = 1'b0;
                  if (sram_read_r) begin
                     m1_rdata_s = sram_data_read;
                  end else begin
                     m1_rdata_s = m1_rdata_r;
                  end
               end else begin
                  m0_ack_s = 1'b1;
                  m0_err_s = 1'b0;
                  if (sram_read_r) begin
                     m0_rdata_s = sram_data_read;
                  end else begin
                     m0_rdata_s = m0_rdata_r;
                  end
               end
            end else if (wdog_hit_s) begin
               sram_read_s  = 1'b0;
               sram_write_s = 1'b0;
               state_s      = ST_RECOVER;
               if (owner_r) begin
                  m1_ack_s   = 1'b1;
                  m1_err_s   = 1'b1;
                  m1_rdata_s = {DW{1'b1}};
               end else begin
                  m0_ack_s   = 1'b1;
                  m0_err_s   = 1'b1;
                  m0_rdata_s = {DW{1'b1}};
               end
            end else begin
               state_s = ST_BUSY;
            end
         end

         // One gap cycle so a registered master can drop req after its ack.
         ST_RECOVER: begin
            m0_ack_s = 1'b0;
            m1_ack_s = 1'b0;
            m0_err_s = 1'b0;
            m1_err_s = 1'b0;
            busy_s   = 1'b0;
            state_s  = ST_IDLE;
         end

         default: begin
            sram_read_s  = 1'b0;
            sram_write_s = 1'b0;
            m0_ack_s     = 1'b0;
            m1_ack_s     = 1'b0;
            busy_s       = 1'b0;
            state_s      = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r           <= ST_IDLE;
         wdog_r            <= {WDW{1'b0}};
         last_grant_r      <= 1'b1;
         owner_r           <= 1'b0;
         busy_r            <= 1'b0;
         sram_read_r       <= 1'b0;
         sram_write_r      <= 1'b0;
         sram_address_r    <= {AW{1'b0}};
         sram_data_write_r <= {DW{1'b0}};
         m0_ack_r          <= 1'b0;
         m1_ack_r          <= 1'b0;
         m0_err_r          <= 1'b0;
         m1_err_r          <= 1'b0;
         m0_rdata_r        <= {DW{1'b0}};
         m1_rdata_r        <= {DW{1'b0}};
      end else begin
         state_r           <= state_s;
         wdog_r            <= wdog_s;
         last_grant_r      <= last_grant_s;
         owner_r           <= owner_s;
         busy_r            <= busy_s;
         sram_read_r       <= sram_read_s;
         sram_write_r      <= sram_write_s;
         sram_address_r    <= sram_address_s;
         sram_data_write_r <= sram_data_write_s;
         m0_ack_r          <= m0_ack_s;
         m1_ack_r          <= m1_ack_s;
         m0_err_r          <= m0_err_s;
         m1_err_r          <= m1_err_s;
         m0_rdata_r        <= m0_rdata_s;
         m1_rdata_r        <= m1_rdata_s;
      end
   end

   assign m0_ack          = m0_ack_r;
   assign m1_ack          = m1_ack_r;
   assign m0_err          = m0_err_r;
   assign m1_err          = m1_err_r;
   assign m0_rdata        = m0_rdata_r;
   assign m1_rdata        = m1_rdata_r;
   assign sram_read       = sram_read_r;
   assign sram_write      = sram_write_r;
   assign sram_address    = sram_address_r;
   assign sram_data_write = sram_data_write_r;
   assign busy            = busy_r;
   assign owner           = owner_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Directed bench for sram_arbiter (AW=18, DW=16, TIMEOUT=8). Inputs are
//   driven and outputs sampled on the falling clock edge. The SRAM controller
//   is modelled by access_wait: it counts strobe cycles and raises ready after
//   a chosen number of them (0 = never, to exercise the watchdog).
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   logic        clk;
   logic        reset_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [17:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [15:0] m0_rdata, m1_rdata;
   logic        sram_read, sram_write;
   logic [17:0] sram_address;
   logic [15:0] sram_data_write, sram_data_read;
   logic        sram_ready;
   logic        busy, owner;

   int          n_checks;
   int          n_pass;

   // results of the last access_wait call
   logic        res_done;
   int          res_strobes;
   logic [1:0]  res_ack;
   logic        res_err, res_owner, res_rd, res_wr, res_both, res_stable;
   logic [17:0] res_addr;
   logic [15:0] res_wdata;
   logic [3:0]  grants;

   sram_arbiter #(.AW(18), .DW(16), .TIMEOUT(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .sram_read(sram_read), .sram_write(sram_write), .sram_address(sram_address),
      .sram_data_write(sram_data_write), .sram_data_read(sram_data_read),
      .sram_ready(sram_ready), .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Play the SRAM controller until an ack is seen (bounded). lat = strobe
   // cycles before ready rises; 0 never raises ready. drop0 releases m0_req
   // on the first strobe cycle.
   task automatic access_wait(input int lat, input logic [15:0] rd, input logic drop0);
      res_done = 1'b0; res_strobes = 0; res_ack = 2'b00; res_err = 1'b0;
      res_rd = 1'b0; res_wr = 1'b0; res_both = 1'b0; res_stable = 1'b1;
      for (int i = 0; i < 200 && !res_done; i++) begin
         @(negedge clk);
         if (m0_ack || m1_ack) begin
            res_done       = 1'b1;
            res_ack        = {m1_ack, m0_ack};
            res_err        = m0_err | m1_err;
            res_owner      = owner;
            sram_ready     = 1'b0;
            sram_data_read = 16'h0000;
         end else if (sram_read || sram_write) begin
            res_strobes++;
            res_rd   = res_rd | sram_read;
            res_wr   = res_wr | sram_write;
            res_both = res_both | (sram_read & sram_write);
            if (res_strobes == 1) begin
               res_addr  = sram_address;
               res_wdata = sram_data_write;
               if (drop0) m0_req = 1'b0;
            end else begin
               res_stable = res_stable & (sram_address == res_addr);
            end
            if (lat != 0 && res_strobes == lat) begin
               sram_ready     = 1'b1;
               sram_data_read = rd;
            end
         end
      end
      if (!res_done) check_eq("ack_wait_expired", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got timeout expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      n_checks = 0; n_pass = 0;
      reset_n = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = 18'h0; m0_wdata = 16'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 18'h0; m1_wdata = 16'h0;
      sram_ready = 1'b0; sram_data_read = 16'h0;
      repeat (2) @(negedge clk);

      // reset state
      check_eq("rst_strobes", {30'd0, sram_read, sram_write}, 32'd0);
      check_eq("rst_acks_errs", {28'd0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
      check_eq("rst_busy_owner", {30'd0, busy, owner}, 32'd0);
      check_eq("rst_addr", {14'd0, sram_address}, 32'd0);
      check_eq("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // 1: m0 read, ready after 2 strobe cycles
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00123;
      access_wait(2, 16'h00A5, 1'b0);
      check_eq("t1_ack", {30'd0, res_ack}, 32'd1);
      check_eq("t1_rdata", {16'd0, m0_rdata}, 32'h00A5);
      check_eq("t1_err", {31'd0, res_err}, 32'd0);
      check_eq("t1_strobe_cycles", res_strobes, 32'd2);
      check_eq("t1_rd_wr", {30'd0, res_rd, res_wr}, 32'd2);
      check_eq("t1_addr", {14'd0, res_addr}, 32'h00123);
      check_eq("t1_m1_rdata_hold", {16'd0, m1_rdata}, 32'd0);
      m0_req = 1'b0;
      @(negedge clk);
      check_eq("t1_ack_one_cycle", {31'd0, m0_ack}, 32'd0);
      check_eq("t1_idle", {31'd0, busy}, 32'd0);

      // 2: m1 write to the top address
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 18'h3FFFF; m1_wdata = 16'hBEEF;
      access_wait(1, 16'h5555, 1'b0);
      check_eq("t2_ack", {30'd0, res_ack}, 32'd2);
      check_eq("t2_rd_wr", {30'd0, res_rd, res_wr}, 32'd1);
      check_eq("t2_addr", {14'd0, res_addr}, 32'h3FFFF);
      check_eq("t2_wdata", {16'd0, res_wdata}, 32'hBEEF);
      check_eq("t2_m1_rdata_unchanged", {16'd0, m1_rdata}, 32'd0);
      check_eq("t2_m0_rdata_hold", {16'd0, m0_rdata}, 32'h00A5);
      check_eq("t2_owner", {31'd0, res_owner}, 32'd1);
      m1_req = 1'b0;
      @(negedge clk);

      // 3: both request continuously for four accesses
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 18'h00010; m0_wdata = 16'h1111;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 18'h00020; m1_wdata = 16'h2222;
      for (int k = 0; k < 4; k++) begin
         access_wait(1, 16'h0000, 1'b0);
         grants[k] = res_owner;
         check_eq("t3_addr_vs_owner", {14'd0, res_addr}, res_owner ? 32'h00020 : 32'h00010);
      end
`ifdef SRAM_ARB_RR_EN
      check_eq("t3_grant_order", {28'd0, grants}, 32'hA);
`else
      check_eq("t3_grant_order", {28'd0, grants}, 32'h0);
`endif
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(negedge clk);

      // 4: watchdog abort, ready never comes
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00777;
      access_wait(0, 16'h0000, 1'b0);
      check_eq("t4_strobe_cycles", res_strobes, 32'd8);
      check_eq("t4_ack", {30'd0, res_ack}, 32'd1);
      check_eq("t4_err", {31'd0, res_err}, 32'd1);
      check_eq("t4_rdata", {16'd0, m0_rdata}, 32'hFFFF);
      check_eq("t4_addr_stable", {31'd0, res_stable}, 32'd1);
      m0_req = 1'b0;
      @(negedge clk);
      check_eq("t4_idle", {30'd0, busy, m0_err}, 32'd0);

      // ready arriving on the watchdog's last cycle wins
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h00042;
      access_wait(8, 16'h1234, 1'b0);
      check_eq("t4b_err", {31'd0, res_err}, 32'd0);
      check_eq("t4b_rdata", {16'd0, m1_rdata}, 32'h1234);
      check_eq("t4b_m0_hold", {16'd0, m0_rdata}, 32'hFFFF);
      m1_req = 1'b0;
      @(negedge clk);

      // 5: reset in the middle of an access
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h00099;
      for (int i = 0; i < 20 && !sram_read; i++) @(negedge clk);
      check_eq("t5_strobe_seen", {31'd0, sram_read}, 32'd1);
      reset_n = 1'b0;
      m1_req = 1'b0;
      @(negedge clk);
      check_eq("t5_strobes_dropped", {30'd0, sram_read, sram_write}, 32'd0);
      check_eq("t5_no_ack_busy", {29'd0, m1_ack, m0_ack, busy}, 32'd0);
      reset_n = 1'b1;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00001;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 18'h00002;
      access_wait(1, 16'hC0DE, 1'b0);
      check_eq("t5_tie_to_m0", {30'd0, res_ack}, 32'd1);
      check_eq("t5_rdata", {16'd0, m0_rdata}, 32'hC0DE);
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(negedge clk);

      // 6: m0 drops req during BUSY
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 18'h00200;
      access_wait(2, 16'h0F0F, 1'b1);
      check_eq("t6_ack", {30'd0, res_ack}, 32'd1);
      check_eq("t6_rdata", {16'd0, m0_rdata}, 32'h0F0F);
      check_eq("t6_never_both", {31'd0, res_both}, 32'd0);
      repeat (2) @(negedge clk);
      check_eq("t6_no_second_access", {29'd0, sram_read, sram_write, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
